// File: rtl/sram_controller.sv
// sram_controller
// Memory-side responder for the MEM stage's 32-bit load/store interface.
// A held read or write request is split into two 16-bit accesses on the
// external SRAM bus, low half first. ready stays low until the access
// completes, which freezes the pipeline for the duration.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   wr_en, rd_en      store / load request, held until ready=1
//   address, wdata    byte address and store data, held stable by upstream
//   rdata             load data, valid from the ready=1 cycle of a read
//   ready             high when idle with no request, or on completion
//   SRAM_*            board SRAM pins, passed straight to the top level
module sram_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_isWrite;
  logic [31:0]   r_rdata;
  logic [17:0]   r_sramAddr;
  logic          r_weN;
  logic          r_oeN;
  logic          r_dqEn;
  logic [15:0]   r_dqOut;

  logic [31:0]   w_offset;
  logic [16:0]   w_wordAddr;
  logic          w_lastCycle;
  logic          w_unused;

  // Offset wraps at 32 bits; only bits [18:2] select the SRAM word, the
  // remaining bits are deliberately ignored (no range check).
  assign w_offset    = address - 32'(BASE_ADDR);
  assign w_wordAddr  = w_offset[18:2];
  assign w_unused    = ^{w_offset[31:19], w_offset[1:0]};
  assign w_lastCycle = (r_count == CW'(ACCESS_CYCLES - 1));

  // Byte lanes and chip enable are always active; all accesses are 16-bit.
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_ADDR = r_sramAddr;
  assign SRAM_WE_N = r_weN;
  assign SRAM_OE_N = r_oeN;
  assign rdata     = r_rdata;

  // The bus is only driven during the halves of a write, so it can never
  // fight the SRAM while its output enable is asserted.
  assign SRAM_DQ = r_dqEn ? r_dqOut : 16'hzzzz;

  // A fresh request in IDLE pulls ready low in the same cycle; DONE raises
  // it for one cycle so the pipeline advances.
  assign ready = ((r_state == IDLE) && !rd_en && !wr_en) || (r_state == DONE);

  // Single FSM with registered bus outputs. Bus controls are loaded on the
  // edge that enters a state so they are valid for that state's whole
  // duration. Read halves are captured on the final cycle of each half.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_isWrite  <= 1'b0;
      r_rdata    <= '0;
      r_sramAddr <= '0;
      r_weN      <= 1'b1;
      r_oeN      <= 1'b1;
      r_dqEn     <= 1'b0;
      r_dqOut    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (wr_en || rd_en) begin
            r_state    <= LO;
            r_count    <= '0;
            r_isWrite  <= wr_en;
            r_sramAddr <= {w_wordAddr, 1'b0};
            r_weN      <= !wr_en;
            r_oeN      <= wr_en;
            r_dqEn     <= wr_en;
            r_dqOut    <= wdata[15:0];
          end
        end
        LO: begin
          if (w_lastCycle) begin
            r_state    <= HI;
            r_count    <= '0;
            r_sramAddr <= {w_wordAddr, 1'b1};
            r_dqOut    <= wdata[31:16];
            if (!r_isWrite) begin
              r_rdata[15:0] <= SRAM_DQ;
            end
          end else begin
            r_count    <= r_count + CW'(1);
            r_sramAddr <= {w_wordAddr, 1'b0};
            r_dqOut    <= wdata[15:0];
          end
        end
        HI: begin
          if (w_lastCycle) begin
            r_state <= DONE;
            r_count <= '0;
            r_weN   <= 1'b1;
            r_oeN   <= 1'b1;
            r_dqEn  <= 1'b0;
            if (!r_isWrite) begin
              r_rdata[31:16] <= SRAM_DQ;
            end
          end else begin
            r_count    <= r_count + CW'(1);
            r_sramAddr <= {w_wordAddr, 1'b1};
            r_dqOut    <= wdata[31:16];
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
// Directed bench for sram_controller with a tiny SRAM model on the DQ bus.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  wire  [15:0] sramDq;
  logic [17:0] sramAddr;
  logic        sramUbN;
  logic        sramLbN;
  logic        sramWeN;
  logic        sramCeN;
  logic        sramOeN;

  logic [15:0] mem [0:15];

  int nCompared   = 0;
  int nMismatched = 0;

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (sramDq),
    .SRAM_ADDR (sramAddr),
    .SRAM_UB_N (sramUbN),
    .SRAM_LB_N (sramLbN),
    .SRAM_WE_N (sramWeN),
    .SRAM_CE_N (sramCeN),
    .SRAM_OE_N (sramOeN)
  );

  always #5 clk = ~clk;

  // SRAM model: drives the bus while output-enabled, stores on write strobe.
  // Reset reloads the two read-test halves.
  assign sramDq = (!sramOeN) ? mem[sramAddr[3:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (rst) begin
      mem[2] <= 16'h5678;
      mem[3] <= 16'h1234;
    end else if (!sramWeN) begin
      mem[sramAddr[3:0]] <= sramDq;
    end
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic [31:0] addr, input logic [31:0] data);
    wr_en   = wr;
    rd_en   = rd;
    address = addr;
    wdata   = data;
  endtask

  // Presents a request in cycle 0 and checks the bus every cycle through
  // DONE (cycle 5). The request is left held through DONE.
  task automatic doAccess(input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic expWrite, input logic [17:0] expLoHalf);
    applyStimulus(wr, rd, addr, data);
    #1;
    checkOutput("c0_ready", 32'(ready), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("c%0d_ready", c), 32'(ready), 32'd0);
      checkOutput($sformatf("c%0d_addr", c), 32'(sramAddr),
                  32'(expLoHalf) + ((c > 2) ? 32'd1 : 32'd0));
      checkOutput($sformatf("c%0d_we_n", c), 32'(sramWeN),
                  expWrite ? 32'd0 : 32'd1);
      checkOutput($sformatf("c%0d_oe_n", c), 32'(sramOeN),
                  expWrite ? 32'd1 : 32'd0);
      if (expWrite) begin
        checkOutput($sformatf("c%0d_dq", c), 32'(sramDq),
                    (c > 2) ? 32'(data[31:16]) : 32'(data[15:0]));
      end
    end
    @(negedge clk);
    checkOutput("c5_ready", 32'(ready), 32'd1);
    checkOutput("c5_we_n", 32'(sramWeN), 32'd1);
    checkOutput("c5_oe_n", 32'(sramOeN), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset and idle");
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_we_n", 32'(sramWeN), 32'd1);
    checkOutput("rst_oe_n", 32'(sramOeN), 32'd1);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_addr", 32'(sramAddr), 32'd0);
    checkOutput("const_pins", {28'd0, sramUbN, sramLbN, sramCeN, 1'b0}, 32'd0);

    $display("[TB] write 0xDEADBEEF to 1024");
    doAccess(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b1, 18'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("wr_mem0", 32'(mem[0]), 32'h0000BEEF);
    checkOutput("wr_mem1", 32'(mem[1]), 32'h0000DEAD);
    checkOutput("wr_rdata", rdata, 32'd0);

    $display("[TB] read from 1028");
    doAccess(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, 18'd2);
    checkOutput("rd_rdata", rdata, 32'h12345678);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("rd_hold", rdata, 32'h12345678);
    checkOutput("rd_idle_ready", 32'(ready), 32'd1);

    $display("[TB] both enables at 1032");
    doAccess(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b1, 18'd4);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("both_rdata", rdata, 32'h12345678);
    checkOutput("both_mem4", 32'(mem[4]), 32'h00005A5A);
    checkOutput("both_mem5", 32'(mem[5]), 32'h0000A5A5);

    $display("[TB] back-to-back write then read at 1036");
    doAccess(1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 1'b1, 18'd6);
    @(negedge clk);
    doAccess(1'b0, 1'b1, 32'd1036, 32'd0, 1'b0, 18'd6);
    checkOutput("b2b_rdata", rdata, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("b2b_idle_ready", 32'(ready), 32'd1);
    checkOutput("b2b_idle_we_n", 32'(sramWeN), 32'd1);

    $display("[TB] reset during high half of a write");
    applyStimulus(1'b1, 1'b0, 32'd1040, 32'h11112222);
    repeat (3) @(negedge clk);
    checkOutput("mid_we_n", 32'(sramWeN), 32'd0);
    checkOutput("mid_addr", 32'(sramAddr), 32'd9);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_ready", 32'(ready), 32'd1);
    checkOutput("mid_rst_we_n", 32'(sramWeN), 32'd1);
    checkOutput("mid_rst_oe_n", 32'(sramOeN), 32'd1);
    checkOutput("mid_rst_rdata", rdata, 32'd0);
    checkOutput("mid_rst_addr", 32'(sramAddr), 32'd0);
    checkOutput("mid_rst_mem8", 32'(mem[8]), 32'h00002222);
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
